// File: rtl/vga_rect_filler.sv
// Rectangle-fill engine: accepts one rectangle per handshake and streams
// one pixel write per clock, row-major, suppressing the strobe off-screen.
module vga_rect_filler #(
    parameter int XW      = 10,
    parameter int YW      = 9,
    parameter int COLOR_W = 24,
    parameter int XMAX    = 640,
    parameter int YMAX    = 480
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [XW-1:0]      req_x,
    input  logic [YW-1:0]      req_y,
    input  logic [XW-1:0]      req_w,
    input  logic [YW-1:0]      req_h,
    input  logic [COLOR_W-1:0] req_color,
    input  logic               abort,
    output logic [XW-1:0]      VGA_X,
    output logic [YW-1:0]      VGA_Y,
    output logic [COLOR_W-1:0] VGA_COLOR,
    output logic               plot,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [XW:0] X_LIM = (XW+1)'(XMAX);
    localparam logic [YW:0] Y_LIM = (YW+1)'(YMAX);

    state_t state;
    state_t state_n;

    logic [XW-1:0]      x0;
    logic [XW-1:0]      w;
    logic [XW-1:0]      cx;
    logic [XW-1:0]      cx_n;
    logic [YW-1:0]      y0;
    logic [YW-1:0]      h;
    logic [YW-1:0]      cy;
    logic [YW-1:0]      cy_n;
    logic [COLOR_W-1:0] color;

    logic        accept;
    logic        empty;
    logic        col_end;
    logic        last;
    logic        stop;
    logic [XW:0] px_n;
    logic [YW:0] py_n;
    logic        on_req;
    logic        on_next;

    assign req_ready = (state == IDLE);
    assign busy      = (state == DRAW);
    assign done      = (state == DONE);

    // cx/cy index the pixel currently on the outputs; *_n is the one after it
    always_comb begin
        accept  = req_valid && req_ready;
        empty   = (req_w == '0) || (req_h == '0);
        col_end = (cx == w - XW'(1));
        last    = col_end && (cy == h - YW'(1));
        stop    = last || abort;
        cx_n    = col_end ? '0 : cx + XW'(1);
        cy_n    = col_end ? cy + YW'(1) : cy;
        px_n    = {1'b0, x0} + {1'b0, cx_n};
        py_n    = {1'b0, y0} + {1'b0, cy_n};
        on_req  = ({1'b0, req_x} < X_LIM) && ({1'b0, req_y} < Y_LIM);
        on_next = (px_n < X_LIM) && (py_n < Y_LIM);
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = empty ? DONE : DRAW;
                end
            end
            DRAW: begin
                if (stop) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // First pixel is registered on the accept edge so it shows the next cycle
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            x0        <= '0;
            y0        <= '0;
            w         <= '0;
            h         <= '0;
            color     <= '0;
            cx        <= '0;
            cy        <= '0;
            VGA_X     <= '0;
            VGA_Y     <= '0;
            VGA_COLOR <= '0;
            plot      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    plot <= 1'b0;
                    if (accept) begin
                        x0    <= req_x;
                        y0    <= req_y;
                        w     <= req_w;
                        h     <= req_h;
                        color <= req_color;
                        cx    <= '0;
                        cy    <= '0;
                        if (!empty) begin
                            VGA_X     <= req_x;
                            VGA_Y     <= req_y;
                            VGA_COLOR <= req_color;
                            plot      <= on_req;
                        end
                    end
                end
                DRAW: begin
                    if (stop) begin
                        plot <= 1'b0;
                    end else begin
                        cx        <= cx_n;
                        cy        <= cy_n;
                        VGA_X     <= px_n[XW-1:0];
                        VGA_Y     <= py_n[YW-1:0];
                        VGA_COLOR <= color;
                        plot      <= on_next;
                    end
                end
                default: begin
                    plot <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_rect_filler.sv
// Bench for vga_rect_filler: request table with a pixel scoreboard plus
// hand-written sequences for hold, abort and mid-draw reset.
module tb_vga_rect_filler;

    localparam int XW      = 10;
    localparam int YW      = 9;
    localparam int COLOR_W = 24;

    logic               CLOCK_50;
    logic               reset;
    logic               req_valid;
    logic               req_ready;
    logic [XW-1:0]      req_x;
    logic [YW-1:0]      req_y;
    logic [XW-1:0]      req_w;
    logic [YW-1:0]      req_h;
    logic [COLOR_W-1:0] req_color;
    logic               abort;
    logic [XW-1:0]      VGA_X;
    logic [YW-1:0]      VGA_Y;
    logic [COLOR_W-1:0] VGA_COLOR;
    logic               plot;
    logic               busy;
    logic               done;

    vga_rect_filler dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_w     (req_w),
        .req_h     (req_h),
        .req_color (req_color),
        .abort     (abort),
        .VGA_X     (VGA_X),
        .VGA_Y     (VGA_Y),
        .VGA_COLOR (VGA_COLOR),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [XW-1:0]      x;
        logic [YW-1:0]      y;
        logic [COLOR_W-1:0] c;
    } pix_t;

    typedef struct {
        int          x;
        int          y;
        int          w;
        int          h;
        logic [23:0] c;
        int          plots;
        int          cycles;
    } vec_t;

    pix_t sb[$];
    int   n_chk;
    int   n_fail;
    int   plot_cnt;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: on-screen pixels of a rectangle in row-major order
    task automatic push_rect(input int x, input int y, input int w,
                             input int h, input logic [23:0] c,
                             input int limit);
        int n;
        pix_t p;
        n = 0;
        for (int r = 0; r < h; r++) begin
            for (int k = 0; k < w; k++) begin
                if (n < limit && x + k < 640 && y + r < 480) begin
                    p.x = XW'(x + k);
                    p.y = YW'(y + r);
                    p.c = c;
                    sb.push_back(p);
                end
                n++;
            end
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (!reset && plot) begin
            plot_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_plot", {VGA_X, VGA_Y}, 64'h0);
                n_chk++;
                n_fail++;
                $display("FAIL extra_pixel: got plot at (%0d,%0d) expected none",
                         VGA_X, VGA_Y);
            end else begin
                chk("pixel", {VGA_X, VGA_Y, VGA_COLOR}, sb.pop_front());
            end
        end
    end

    task automatic drive(input int x, input int y, input int w, input int h,
                         input logic [23:0] c);
        req_x     = XW'(x);
        req_y     = YW'(y);
        req_w     = XW'(w);
        req_h     = YW'(h);
        req_color = c;
        req_valid = 1'b1;
    endtask

    task automatic run(input vec_t v);
        int n;
        int busy_n;
        @(negedge CLOCK_50);
        plot_cnt = 0;
        chk("ready_idle", req_ready, 1);
        drive(v.x, v.y, v.w, v.h, v.c);
        push_rect(v.x, v.y, v.w, v.h, v.c, 1 << 30);
        @(posedge CLOCK_50);
        #1 req_valid = 1'b0;
        n = 0;
        busy_n = 0;
        do begin
            @(negedge CLOCK_50);
            n++;
            if (busy) busy_n++;
        end while (!done && n < 4000);
        chk("done_latency", n, v.cycles);
        chk("busy_cycles", busy_n, v.w * v.h);
        chk("plot_count", plot_cnt, v.plots);
        chk("sb_empty", sb.size(), 0);
        @(negedge CLOCK_50);
        chk("done_pulse", done, 0);
        chk("ready_back", req_ready, 1);
    endtask

    vec_t vecs[8];

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        plot_cnt  = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        abort     = 1'b0;
        req_x     = '0;
        req_y     = '0;
        req_w     = '0;
        req_h     = '0;
        req_color = '0;

        vecs[0] = '{10, 20, 2, 2, 24'hFF0000, 4, 5};
        vecs[1] = '{5, 5, 0, 5, 24'h123456, 0, 1};
        vecs[2] = '{638, 0, 4, 1, 24'h0000FF, 2, 5};
        vecs[3] = '{0, 0, 1, 1, 24'hABCDEF, 1, 2};
        vecs[4] = '{636, 476, 4, 4, 24'h00FF00, 16, 17};
        vecs[5] = '{630, 478, 3, 5, 24'h777777, 6, 16};
        vecs[6] = '{7, 9, 3, 0, 24'h111111, 0, 1};
        vecs[7] = '{1000, 100, 3, 2, 24'h222222, 0, 7};

        repeat (3) @(negedge CLOCK_50);
        chk("rst_x", VGA_X, 0);
        chk("rst_y", VGA_Y, 0);
        chk("rst_color", VGA_COLOR, 0);
        chk("rst_flags", {plot, busy, done, req_ready}, 4'b0001);
        reset = 1'b0;

        // abort while idle must be ignored
        @(negedge CLOCK_50);
        abort = 1'b1;
        @(negedge CLOCK_50);
        abort = 1'b0;
        chk("abort_idle", {busy, done, req_ready}, 3'b001);

        for (int i = 0; i < 8; i++) run(vecs[i]);

        // second request held valid while the first one draws
        @(negedge CLOCK_50);
        plot_cnt = 0;
        drive(100, 50, 2, 1, 24'hAAAAAA);
        push_rect(100, 50, 2, 1, 24'hAAAAAA, 1 << 30);
        push_rect(200, 60, 1, 2, 24'hBBBBBB, 1 << 30);
        @(posedge CLOCK_50);
        #1 drive(200, 60, 1, 2, 24'hBBBBBB);
        for (int n = 1; n <= 8; n++) begin
            @(negedge CLOCK_50);
            if (n <= 3) chk("hold_not_ready", req_ready, 0);
            if (n == 3) chk("hold_done_a", done, 1);
            if (n == 4) chk("hold_idle", {req_ready, done, plot}, 3'b100);
            if (n == 5) chk("hold_b_first", {plot, VGA_X}, {1'b1, 10'd200});
            if (n == 7) chk("hold_done_b", done, 1);
            if (n == 4) begin
                @(posedge CLOCK_50);
                #1 req_valid = 1'b0;
            end
        end
        chk("hold_plots", plot_cnt, 4);
        chk("hold_sb", sb.size(), 0);

        // abort during the third pixel of a 4x4 rectangle
        @(negedge CLOCK_50);
        plot_cnt = 0;
        drive(300, 200, 4, 4, 24'hC0FFEE);
        push_rect(300, 200, 4, 4, 24'hC0FFEE, 3);
        @(posedge CLOCK_50);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        abort = 1'b1;
        @(posedge CLOCK_50);
        #1 abort = 1'b0;
        @(negedge CLOCK_50);
        chk("abort_done", {done, plot, busy}, 3'b100);
        @(negedge CLOCK_50);
        chk("abort_single", {done, req_ready}, 2'b01);
        chk("abort_plots", plot_cnt, 3);
        chk("abort_sb", sb.size(), 0);

        // abort coinciding with the last pixel
        @(negedge CLOCK_50);
        plot_cnt = 0;
        drive(40, 41, 2, 1, 24'h0F0F0F);
        push_rect(40, 41, 2, 1, 24'h0F0F0F, 1 << 30);
        @(posedge CLOCK_50);
        #1 req_valid = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        abort = 1'b1;
        @(posedge CLOCK_50);
        #1 abort = 1'b0;
        @(negedge CLOCK_50);
        chk("abort_last_done", done, 1);
        @(negedge CLOCK_50);
        chk("abort_last_once", done, 0);
        chk("abort_last_plots", plot_cnt, 2);

        // reset in the middle of a draw
        @(negedge CLOCK_50);
        drive(20, 30, 4, 4, 24'h445566);
        push_rect(20, 30, 4, 4, 24'h445566, 1 << 30);
        @(posedge CLOCK_50);
        #1 req_valid = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b1;
        #1;
        chk("mid_rst_xy", {VGA_X, VGA_Y}, 0);
        chk("mid_rst_color", VGA_COLOR, 0);
        chk("mid_rst_flags", {plot, busy, done, req_ready}, 4'b0001);
        sb.delete();
        @(negedge CLOCK_50);
        reset = 1'b0;
        run(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
